// File: rtl/memgame_pkg.sv
// Shared types and constants for the 4x4 memory-card game sequencer.
package memgame_pkg;
    typedef enum logic [2:0] {PICK1, PICK2, SHOW, CHECK, DONE} state_t;

    localparam int NUM_CARDS = 16;
    localparam int NUM_PAIRS = 8;
    localparam int POS_W     = 4;
    localparam int ID_W      = 3;

    function automatic logic [1:0] pos_col(input logic [POS_W-1:0] p);
        return p[1:0];
    endfunction

    function automatic logic [1:0] pos_row(input logic [POS_W-1:0] p);
        return p[3:2];
    endfunction
endpackage

// File: rtl/memgame_cursor.sv
// Wrap-around board cursor; column and row step independently and may move together.
module memgame_cursor
    import memgame_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_right,
    input  logic             i_down,
    output logic [POS_W-1:0] o_pos
);
    logic [1:0] w_col;
    logic [1:0] w_row;

    // 2-bit adds give the 3->0 wrap for free
    assign w_col = pos_col(o_pos) + (i_en && i_right ? 2'd1 : 2'd0);
    assign w_row = pos_row(o_pos) + (i_en && i_down  ? 2'd1 : 2'd0);

    always_ff @(posedge clk) begin
        if (reset) o_pos <= '0;
        else       o_pos <= {w_row, w_col};
    end
endmodule

// File: rtl/memgame_ctrl.sv
// Memory-card game sequencer: selection FSM, reveal hold, matched/score bookkeeping.
// Optional attempt limit enabled by defining MEMGAME_ATTEMPT_LIMIT_EN.
module memgame_ctrl
    import memgame_pkg::*;
#(
    parameter logic [63:0] DECK         = 64'h7654_3210_7654_3210,
    parameter int          SHOW_CYCLES  = 25_000_000,
    parameter int          MAX_ATTEMPTS = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_right,
    input  logic                 btn_down,
    input  logic                 btn_sel,
    input  logic                 btn_start,
    output logic [POS_W-1:0]     cursor,
    output logic [NUM_CARDS-1:0] face_up,
    output logic [NUM_CARDS-1:0] matched,
    output logic [3:0]           pairs,
    output logic [4:0]           attempts,
    output logic                 busy,
    output logic                 game_over,
    output logic                 win
);
    localparam int CNT_W = $clog2(SHOW_CYCLES + 1);

    state_t                 r_state, w_state_nxt;
    logic [NUM_CARDS-1:0]   r_face, w_face_nxt;
    logic [NUM_CARDS-1:0]   r_matched, w_matched_nxt;
    logic [3:0]             r_pairs, w_pairs_nxt;
    logic [4:0]             r_att, w_att_nxt;
    logic [POS_W-1:0]       r_first, w_first_nxt;
    logic [POS_W-1:0]       r_second, w_second_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_busy, r_over, r_win;
    logic                   w_sel_ok;
    logic [ID_W-1:0]        w_id_first, w_id_second;

    memgame_cursor u_cursor (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_state != DONE),
        .i_right (btn_right),
        .i_down  (btn_down),
        .o_pos   (cursor)
    );

    // cursor is the registered, pre-move position
    assign w_sel_ok    = btn_sel && !r_face[cursor] && !r_matched[cursor];
    assign w_id_first  = DECK[{r_first, 2'b00} +: ID_W];
    assign w_id_second = DECK[{r_second, 2'b00} +: ID_W];

`ifndef MEMGAME_ATTEMPT_LIMIT_EN
    logic w_unused_max;
    assign w_unused_max = ^MAX_ATTEMPTS;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_face_nxt    = r_face;
        w_matched_nxt = r_matched;
        w_pairs_nxt   = r_pairs;
        w_att_nxt     = r_att;
        w_first_nxt   = r_first;
        w_second_nxt  = r_second;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            PICK1: if (w_sel_ok) begin
                w_face_nxt[cursor] = 1'b1;
                w_first_nxt        = cursor;
                w_state_nxt        = PICK2;
            end
            PICK2: if (w_sel_ok) begin
                w_face_nxt[cursor] = 1'b1;
                w_second_nxt       = cursor;
                w_cnt_nxt          = '0;
                w_state_nxt        = SHOW;
            end
            SHOW: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(SHOW_CYCLES - 1)) w_state_nxt = CHECK;
            end
            CHECK: begin
                w_att_nxt = (r_att == 5'd31) ? r_att : r_att + 5'd1;
                w_face_nxt[r_first]  = 1'b0;
                w_face_nxt[r_second] = 1'b0;
                if (w_id_first == w_id_second) begin
                    w_matched_nxt[r_first]  = 1'b1;
                    w_matched_nxt[r_second] = 1'b1;
                    w_pairs_nxt             = r_pairs + 4'd1;
                end
                if (w_pairs_nxt == 4'(NUM_PAIRS)) w_state_nxt = DONE;
`ifdef MEMGAME_ATTEMPT_LIMIT_EN
                else if (w_att_nxt == 5'(MAX_ATTEMPTS)) w_state_nxt = DONE;
`endif
                else w_state_nxt = PICK1;
            end
            DONE: if (btn_start) begin
                w_face_nxt    = '0;
                w_matched_nxt = '0;
                w_pairs_nxt   = '0;
                w_att_nxt     = '0;
                w_cnt_nxt     = '0;
                w_state_nxt   = PICK1;
            end
            default: w_state_nxt = PICK1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= PICK1;
            r_face    <= '0;
            r_matched <= '0;
            r_pairs   <= '0;
            r_att     <= '0;
            r_first   <= '0;
            r_second  <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_over    <= 1'b0;
            r_win     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_face    <= w_face_nxt;
            r_matched <= w_matched_nxt;
            r_pairs   <= w_pairs_nxt;
            r_att     <= w_att_nxt;
            r_first   <= w_first_nxt;
            r_second  <= w_second_nxt;
            r_cnt     <= w_cnt_nxt;
            // status flags registered from the next state so they align with it
            r_busy    <= (w_state_nxt == SHOW) || (w_state_nxt == CHECK);
            r_over    <= (w_state_nxt == DONE);
            r_win     <= (w_state_nxt == DONE) && (w_pairs_nxt == 4'(NUM_PAIRS));
        end
    end

    assign face_up   = r_face;
    assign matched   = r_matched;
    assign pairs     = r_pairs;
    assign attempts  = r_att;
    assign busy      = r_busy;
    assign game_over = r_over;
    assign win       = r_win;
endmodule

// File: tb/tb_memgame_ctrl.sv
// Directed bench for memgame_ctrl with a short reveal hold; expected values hand-derived.
module tb_memgame_ctrl;
    localparam int SC = 4;
`ifdef MEMGAME_ATTEMPT_LIMIT_EN
    localparam int MAXA = 2;
`else
    localparam int MAXA = 31;
`endif

    logic        clk = 1'b0;
    logic        reset, btn_right, btn_down, btn_sel, btn_start;
    logic [3:0]  cursor;
    logic [15:0] face_up, matched;
    logic [3:0]  pairs;
    logic [4:0]  attempts;
    logic        busy, game_over, win;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    memgame_ctrl #(.SHOW_CYCLES(SC), .MAX_ATTEMPTS(MAXA)) dut (
        .clk(clk), .reset(reset), .btn_right(btn_right), .btn_down(btn_down),
        .btn_sel(btn_sel), .btn_start(btn_start), .cursor(cursor),
        .face_up(face_up), .matched(matched), .pairs(pairs), .attempts(attempts),
        .busy(busy), .game_over(game_over), .win(win)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic d, input logic s, input logic st);
        btn_right = r; btn_down = d; btn_sel = s; btn_start = st;
        @(posedge clk); #1;
        btn_right = 0; btn_down = 0; btn_sel = 0; btn_start = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic goto(input logic [3:0] p);
        for (int i = 0; i < 4 && cursor[1:0] != p[1:0]; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 4 && cursor[3:2] != p[3:2]; i++) step(0, 1, 0, 0);
    endtask

    task automatic pick(input logic [3:0] p);
        goto(p);
        step(0, 0, 1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; btn_right = 0; btn_down = 0; btn_sel = 0; btn_start = 0;
        @(posedge clk); #1;
        do_reset();
        chk("rst_cursor", 32'(cursor), 0);
        chk("rst_face", 32'(face_up), 0);
        chk("rst_matched", 32'(matched), 0);
        chk("rst_pairs", 32'(pairs), 0);
        chk("rst_attempts", 32'(attempts), 0);
        chk("rst_flags", {29'd0, busy, game_over, win}, 0);
`ifdef MEMGAME_ATTEMPT_LIMIT_EN
        pick(4'd0); pick(4'd1); idle(SC + 1);
        chk("lim_att1", 32'(attempts), 1);
        chk("lim_over1", 32'(game_over), 0);
        pick(4'd0); pick(4'd1); idle(SC + 1);
        chk("lim_att2", 32'(attempts), 2);
        chk("lim_over2", 32'(game_over), 1);
        chk("lim_win", 32'(win), 0);
        chk("lim_face", 32'(face_up), 0);
`else
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        chk("cursor_moves", 32'(cursor), 32'b1001);
        step(1, 1, 0, 0);
        chk("cursor_both", 32'(cursor), 32'b1110);
        step(1, 1, 0, 0);
        chk("cursor_wrap", 32'(cursor), 32'b0011);

        // matching pair 0/8 with ignored selects along the way
        do_reset();
        pick(4'd0);
        chk("pick1_face", 32'(face_up), 32'h0001);
        step(0, 0, 1, 0);
        chk("same_pos_ign", 32'(face_up), 32'h0001);
        step(0, 0, 0, 1);
        chk("start_ign", 32'(face_up), 32'h0001);
        pick(4'd8);
        chk("pick2_face", 32'(face_up), 32'h0101);
        chk("pick2_busy", 32'(busy), 1);
        for (int k = 1; k <= SC; k++) begin
            if (k == 1) step(1, 0, 0, 0);
            else if (k == 2) step(0, 0, 1, 0);
            else step(0, 0, 0, 0);
            chk("show_face", 32'(face_up), 32'h0101);
            chk("show_busy", 32'(busy), 1);
        end
        chk("show_cursor", 32'(cursor), 32'd9);
        step(0, 0, 0, 0);
        chk("match_face", 32'(face_up), 0);
        chk("match_mask", 32'(matched), 32'h0101);
        chk("match_pairs", 32'(pairs), 1);
        chk("match_att", 32'(attempts), 1);
        chk("match_busy", 32'(busy), 0);
        pick(4'd0);
        chk("sel_matched_ign", 32'(face_up), 0);
        pick(4'd8);
        chk("sel_matched_ign2", 32'(face_up), 0);

        // mismatch 0/1: visible SC+1 cycles after the second select
        do_reset();
        pick(4'd0); pick(4'd1);
        for (int k = 0; k < SC; k++) begin
            chk("mis_face", 32'(face_up), 32'h0003);
            step(0, 0, 0, 0);
        end
        chk("mis_face_last", 32'(face_up), 32'h0003);
        step(0, 0, 0, 0);
        chk("mis_face_clr", 32'(face_up), 0);
        chk("mis_matched", 32'(matched), 0);
        chk("mis_att", 32'(attempts), 1);
        chk("mis_pairs", 32'(pairs), 0);

        // full game
        do_reset();
        for (int p = 0; p < 8; p++) begin
            pick(4'(p)); pick(4'(p + 8)); idle(SC + 1);
        end
        chk("win_pairs", 32'(pairs), 8);
        chk("win_matched", 32'(matched), 32'hFFFF);
        chk("win_att", 32'(attempts), 8);
        chk("win_flags", {29'd0, busy, game_over, win}, 32'b011);
        step(1, 1, 0, 0);
        chk("done_cursor_hold", 32'(cursor), 32'd15);
        step(0, 0, 1, 0);
        chk("done_sel_ign", 32'(face_up), 0);
        step(0, 0, 0, 1);
        chk("start_pairs", 32'(pairs), 0);
        chk("start_matched", 32'(matched), 0);
        chk("start_att", 32'(attempts), 0);
        chk("start_flags", {29'd0, busy, game_over, win}, 0);
        chk("start_cursor", 32'(cursor), 32'd15);
        step(0, 0, 1, 0);
        chk("start_pick", 32'(face_up), 32'h8000);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
